// File: rtl/arty_reset_pkg.sv
// Shared types and constants for the Arty board reset sequencer.
package arty_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } t_rst_seq_state;

  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/arty_signal_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module arty_signal_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/arty_reset_sequencer.sv
// Ordered domain-reset generator: holds all stages in reset until the MMCM has been
// locked long enough, then releases bit 0 upward; lock loss or a button press restarts.
module arty_reset_sequencer
  import arty_reset_pkg::*;
#(
  parameter int P_NUM_STAGES      = 3,
  parameter int P_STRETCH_CYCLES  = 1024,
  parameter int P_STAGE_GAP       = 16,
  parameter int P_DEBOUNCE_CYCLES = 65536
) (
  input  logic                    i_clk_mhz,
  input  logic                    i_rstn_global,
  input  logic                    i_mmcm_locked,
  input  logic                    i_btn_rst,
  output logic [P_NUM_STAGES-1:0] o_rst_stage,
  output logic                    o_ready,
  output logic [LOCK_CNT_W-1:0]   o_lock_lost_cnt,
  output logic [1:0]              o_state
);

  localparam int STRETCH_W = (P_STRETCH_CYCLES > 1) ? $clog2(P_STRETCH_CYCLES) : 1;
  localparam int GAP_W     = (P_STAGE_GAP > 1) ? $clog2(P_STAGE_GAP) : 1;
  localparam int DEB_W     = $clog2(P_DEBOUNCE_CYCLES + 1);

  // Stretch exits on the edge where the count would become P_STRETCH_CYCLES-1.
  localparam logic [STRETCH_W-1:0] STRETCH_LAST =
    STRETCH_W'((P_STRETCH_CYCLES > 1) ? P_STRETCH_CYCLES - 2 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(P_STAGE_GAP - 1);
  localparam logic [DEB_W-1:0] DEB_TERM = DEB_W'(P_DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_PRE  = DEB_W'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [P_NUM_STAGES-1:0] LAST_PENDING = P_NUM_STAGES'(1) << (P_NUM_STAGES - 1);

  logic                 lock_s;
  logic                 btn_s;
  logic                 lock_prev;
  logic                 press;
  logic [DEB_W-1:0]     deb_cnt;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  t_rst_seq_state       state;

  arty_signal_sync u_lock_sync (
    .clk      (i_clk_mhz),
    .rst_n    (i_rstn_global),
    .async_in (i_mmcm_locked),
    .sync_out (lock_s)
  );

  arty_signal_sync u_btn_sync (
    .clk      (i_clk_mhz),
    .rst_n    (i_rstn_global),
    .async_in (i_btn_rst),
    .sync_out (btn_s)
  );

  // Saturating count means a held button yields exactly one press pulse.
  assign press   = btn_s && (deb_cnt == DEB_PRE);
  assign o_state = state;

  always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
    if (!i_rstn_global) begin
      deb_cnt <= '0;
    end else if (!btn_s) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_TERM) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
    if (!i_rstn_global) begin
      lock_prev       <= 1'b0;
      o_lock_lost_cnt <= '0;
    end else begin
      lock_prev <= lock_s;
      if (lock_prev && !lock_s && (o_lock_lost_cnt != '1))
        o_lock_lost_cnt <= o_lock_lost_cnt + 1'b1;
    end
  end

  // o_rst_stage is a thermometer code; each release shifts one more zero in at bit 0.
  always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
    if (!i_rstn_global) begin
      state       <= ST_HOLD;
      o_rst_stage <= '1;
      o_ready     <= 1'b0;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
    end else if ((state != ST_HOLD) && (!lock_s || press)) begin
      state       <= ST_HOLD;
      o_rst_stage <= '1;
      o_ready     <= 1'b0;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          o_rst_stage <= '1;
          o_ready     <= 1'b0;
          stretch_cnt <= '0;
          gap_cnt     <= '0;
          if (lock_s && !btn_s) begin
            if (P_STRETCH_CYCLES > 1) begin
              state <= ST_STRETCH;
            end else begin
              o_rst_stage <= {P_NUM_STAGES{1'b1}} << 1;
              if (P_NUM_STAGES == 1) begin
                o_ready <= 1'b1;
                state   <= ST_RUN;
              end else begin
                state <= ST_RELEASE;
              end
            end
          end
        end
        ST_STRETCH: begin
          stretch_cnt <= stretch_cnt + 1'b1;
          if (stretch_cnt == STRETCH_LAST) begin
            gap_cnt     <= '0;
            o_rst_stage <= o_rst_stage << 1;
            if (o_rst_stage == LAST_PENDING) begin
              o_ready <= 1'b1;
              state   <= ST_RUN;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt     <= '0;
            o_rst_stage <= o_rst_stage << 1;
            if (o_rst_stage == LAST_PENDING) begin
              o_ready <= 1'b1;
              state   <= ST_RUN;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          o_rst_stage <= '0;
          o_ready     <= 1'b1;
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Directed bench for arty_reset_sequencer: per-edge expected {state, ready, stages}
// words are queued as stimulus is applied and compared on the following falling edges.
module tb_arty_reset_sequencer;

  localparam int N = 3;
  localparam int S = 8;
  localparam int G = 4;
  localparam int D = 5;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  logic         clk;
  logic         rstn;
  logic         locked;
  logic         btn;
  logic [N-1:0] rst_stage;
  logic         ready;
  logic [7:0]   lost_cnt;
  logic [1:0]   state;

  logic [5:0] exp_q[$];
  int checks;
  int failures;

  arty_reset_sequencer #(
    .P_NUM_STAGES      (N),
    .P_STRETCH_CYCLES  (S),
    .P_STAGE_GAP       (G),
    .P_DEBOUNCE_CYCLES (D)
  ) dut (
    .i_clk_mhz       (clk),
    .i_rstn_global   (rstn),
    .i_mmcm_locked   (locked),
    .i_btn_rst       (btn),
    .o_rst_stage     (rst_stage),
    .o_ready         (ready),
    .o_lock_lost_cnt (lost_cnt),
    .o_state         (state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver / scoreboard tasks
  task automatic push(input logic [1:0] st, input logic rdy, input logic [2:0] stg, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({st, rdy, stg});
  endtask

  // pre edges still in reset (the last S-1 of them stretching), then nrel release-phase edges.
  task automatic push_release(input int pre, input int nrel);
    for (int i = 0; i < pre; i++)
      exp_q.push_back({(i >= pre - (S - 1)) ? S_STRETCH : S_HOLD, 1'b0, 3'b111});
    for (int j = 0; j < nrel; j++) begin
      if (j < G)          exp_q.push_back({S_RELEASE, 1'b0, 3'b110});
      else if (j < 2 * G) exp_q.push_back({S_RELEASE, 1'b0, 3'b100});
      else                exp_q.push_back({S_RUN, 1'b1, 3'b000});
    end
  endtask

  task automatic run(input int n, input string tag);
    logic [5:0] e;
    logic [5:0] obs;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL %s edge %0d: no expected value queued", tag, i);
      end else begin
        e   = exp_q.pop_front();
        obs = {state, ready, rst_stage};
        assert (obs === e) else begin
          failures++;
          $error("FAIL %s edge %0d: state/ready/stages got %b expected %b", tag, i, obs, e);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    locked   = 1'b1;
    btn      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_stages", 8'(rst_stage), 8'h07);
    check("reset_ready", 8'(ready), 8'h00);
    check("reset_lost_cnt", lost_cnt, 8'h00);
    rstn = 1'b1;

    // Power-up: stage 0 at E9, stage 1 at E13, stage 2 and ready at E17
    push_release(9, 9);
    run(18, "powerup");
    check("powerup_lost_cnt", lost_cnt, 8'd0);

    // Lock drop in RUN for 10 cycles
    locked = 1'b0;
    push(S_RUN, 1'b1, 3'b000, 2);
    push(S_HOLD, 1'b0, 3'b111, 8);
    run(10, "lock_drop_run");
    locked = 1'b1;
    push_release(9, 9);
    run(18, "relock_release");
    check("lost_cnt_after_drop", lost_cnt, 8'd1);

    // Button shorter than the debounce window
    btn = 1'b1;
    push(S_RUN, 1'b1, 3'b000, 12);
    run(4, "btn_short_held");
    btn = 1'b0;
    run(8, "btn_short_after");

    // Button long enough for one press, held for 20 cycles
    btn = 1'b1;
    push(S_RUN, 1'b1, 3'b000, 6);
    push(S_HOLD, 1'b0, 3'b111, 14);
    run(20, "btn_long_held");
    btn = 1'b0;
    push_release(9, 9);
    run(18, "btn_release_restart");
    check("lost_cnt_after_btn", lost_cnt, 8'd1);

    // Lock glitch in RUN, then lock drop after stage 0 has cleared
    locked = 1'b0;
    push(S_RUN, 1'b1, 3'b000, 2);
    run(1, "glitch_low");
    locked = 1'b1;
    run(1, "glitch_high");
    push_release(8, 2);
    run(10, "glitch_restart");
    locked = 1'b0;
    push(S_RELEASE, 1'b0, 3'b110, 2);
    push(S_HOLD, 1'b0, 3'b111, 4);
    run(6, "drop_in_release");
    check("lost_cnt_after_release_drop", lost_cnt, 8'd3);

    // Lock toggling drives the loss counter into saturation
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      repeat (2) @(negedge clk);
      locked = 1'b0;
      repeat (2) @(negedge clk);
    end
    locked = 1'b1;
    repeat (4) @(negedge clk);
    check("lost_cnt_saturated", lost_cnt, 8'd255);
    check("state_before_async_rst", 8'(state), 8'(S_STRETCH));

    // Asynchronous reset pulse mid-stretch, between edges
    @(posedge clk);
    #3;
    rstn   = 1'b0;
    locked = 1'b0;
    #1;
    check("async_rst_stages", 8'(rst_stage), 8'h07);
    check("async_rst_ready", 8'(ready), 8'h00);
    check("async_rst_lost_cnt", lost_cnt, 8'h00);
    check("async_rst_state", 8'(state), 8'(S_HOLD));

    // Lock low for 50 cycles after reset, then raised
    @(negedge clk);
    rstn = 1'b1;
    push(S_HOLD, 1'b0, 3'b111, 50);
    run(50, "unlocked_hold");
    locked = 1'b1;
    push_release(9, 9);
    run(18, "late_lock_release");
    check("late_lock_lost_cnt", lost_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
